// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with wrap-bit pointers,
// exact occupancy counter, programmable almost-full/almost-empty levels and
// sticky overflow/underflow flags.
// Optional build macro FIFO_FWFT_EN selects first-word-fall-through output;
// when undefined the read port has a fixed one-cycle latency.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 2048,
  parameter int unsigned AF_LEVEL = 1946,
  parameter int unsigned AE_LEVEL = 102
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_data_in,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_data_out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [$clog2(DEPTH):0]   o_used_slot,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] mem [DEPTH];

  // Address = low pointer bits; the MSB only distinguishes full from empty.
  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Status decoded from registered pointers and count.
  assign o_empty        = (wr_ptr == rd_ptr);
  assign o_full         = (wr_addr == rd_addr) && (wr_ptr[AW] != rd_ptr[AW]);
  assign o_almost_full  = (o_used_slot >= PW'(AF_LEVEL));
  assign o_almost_empty = (o_used_slot <  PW'(AE_LEVEL));

  // Requests are accepted only against the current-cycle flags.
  assign wr_acc = i_wr_en && !o_full;
  assign rd_acc = i_rd_en && !o_empty;

  // Pointers, occupancy and sticky error flags; reset overrides any request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_used_slot <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   o_used_slot <= o_used_slot + PW'(1);
        2'b01:   o_used_slot <= o_used_slot - PW'(1);
        default: o_used_slot <= o_used_slot;
      endcase
      if (i_wr_en && o_full)  o_overflow  <= 1'b1;
      if (i_rd_en && o_empty) o_underflow <= 1'b1;
    end
  end

  // Storage array; contents are deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc) mem[wr_addr] <= i_data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word is always presented; forced to zero while empty so the output
  // never shows stale or uninitialised storage.
  assign o_data_out = o_empty ? '0 : mem[rd_addr];
  assign o_valid    = !o_empty;
`else
  // One-cycle read latency; data holds its last value between reads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data_out <= '0;
      o_valid    <= 1'b0;
    end else begin
      o_valid <= rd_acc;
      if (rd_acc) o_data_out <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed table, hand sequences for
// the multi-cycle corner cases, and randomized traffic against a queue model.
module tb_sync_fifo_param;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             wr  = 1'b0;
  logic             rd  = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             valid, full, empty, afull, aempty, ovf, unf;
  logic [4:0]       used;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue plus the read-port and sticky-flag state.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_data  = '0;
  logic             m_valid = 1'b0;
  logic             m_ovf   = 1'b0;
  logic             m_unf   = 1'b0;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .i_clk(clk), .i_rst(rst), .i_data_in(din), .i_wr_en(wr), .i_rd_en(rd),
    .o_data_out(dout), .o_valid(valid), .o_full(full), .o_empty(empty),
    .o_almost_full(afull), .o_almost_empty(aempty), .o_used_slot(used),
    .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic rr, input logic [WIDTH-1:0] d);
    int n;
    n = m_q.size();
    if (r) begin
      m_q.delete();
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (w && n == DEPTH) m_ovf = 1'b1;
      if (rr && n == 0)    m_unf = 1'b1;
      m_valid = 1'b0;
      if (rr && n > 0) begin
        m_data  = m_q.pop_front();
        m_valid = 1'b1;
      end
      if (w && n < DEPTH) m_q.push_back(d);
    end
  endtask

  task automatic compare_all();
    int n;
    n = m_q.size();
    chk("used",   32'(used),   32'(n));
    chk("full",   32'(full),   32'(n == DEPTH));
    chk("empty",  32'(empty),  32'(n == 0));
    chk("afull",  32'(afull),  32'(n >= AF));
    chk("aempty", 32'(aempty), 32'(n < AE));
    chk("ovf",    32'(ovf),    32'(m_ovf));
    chk("unf",    32'(unf),    32'(m_unf));
`ifdef FIFO_FWFT_EN
    chk("data",   32'(dout),   (n == 0) ? 32'd0 : 32'(m_q[0]));
    chk("valid",  32'(valid),  32'(n != 0));
`else
    chk("data",   32'(dout),   32'(m_data));
    chk("valid",  32'(valid),  32'(m_valid));
`endif
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // compare shortly after it.
  task automatic step(input logic r, input logic w, input logic rr, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst = r; wr = w; rd = rr; din = d;
    @(posedge clk);
    model_edge(r, w, rr, d);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic             r, w, rr;
    logic [WIDTH-1:0] d;
    logic [4:0]       e_used;
    logic             e_empty, e_full, e_ovf, e_unf;
  } vec_t;

  vec_t vt[9];

  initial begin
    // Directed table: inputs and the status expected after the edge.
    vt[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 8'h22, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8] = '{1'b1, 1'b1, 1'b0, 8'h55, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(vt[i].r, vt[i].w, vt[i].rr, vt[i].d);
      chk($sformatf("tbl%0d_used", i),  32'(used),  32'(vt[i].e_used));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
      chk($sformatf("tbl%0d_full", i),  32'(full),  32'(vt[i].e_full));
      chk($sformatf("tbl%0d_ovf", i),   32'(ovf),   32'(vt[i].e_ovf));
      chk($sformatf("tbl%0d_unf", i),   32'(unf),   32'(vt[i].e_unf));
    end

    // Reset then idle.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(aempty), 32'd1);
    chk("rst_used", 32'(used), 32'd0);
    chk("rst_data", 32'(dout), 32'd0);
    chk("rst_flags", 32'({ovf, unf}), 32'd0);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, WIDTH'(i));
      chk($sformatf("fill%0d_afull", i), 32'(afull), 32'(i >= 13));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_used", 32'(used), 32'd16);
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_used", 32'(used), 32'd16);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      chk($sformatf("head%0d", i), 32'(dout), 32'(i));
      step(1'b0, 1'b0, 1'b1, 8'h00);
`else
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk($sformatf("rd%0d_data", i), 32'(dout), 32'(i));
      chk($sformatf("rd%0d_valid", i), 32'(valid), 32'd1);
`endif
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("unf_set", 32'(unf), 32'd1);
`ifndef FIFO_FWFT_EN
    chk("unf_data_hold", 32'(dout), 32'h0F);
    chk("unf_valid", 32'(valid), 32'd0);
`endif

    // Half full, then sustained simultaneous traffic across the wrap.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(8'h80 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, WIDTH'(8'h90 + i));
      chk($sformatf("steady%0d_used", i), 32'(used), 32'd8);
    end

    // Both requests while empty, then both while full.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    chk("both_empty_used", 32'(used), 32'd1);
    chk("both_empty_unf", 32'(unf), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(8'hC0 + i));
    chk("pre_both_full_used", 32'(used), 32'd16);
    // Occupancy is DEPTH in the request cycle; only the read is accepted.
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    chk("both_full_ovf", 32'(ovf), 32'd1);
    chk("both_full_used", 32'(used), 32'd15);
`ifndef FIFO_FWFT_EN
    chk("both_full_head", 32'(dout), 32'h5A);
    chk("both_full_valid", 32'(valid), 32'd1);
`endif

    // Drain to 5 words, then reset together with a write request.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("five_used", 32'(used), 32'd5);
    step(1'b1, 1'b1, 1'b0, 8'h77);
    chk("rstwr_used", 32'(used), 32'd0);
    chk("rstwr_empty", 32'(empty), 32'd1);
    chk("rstwr_flags", 32'({ovf, unf}), 32'd0);

    // Single word into an empty FIFO.
    step(1'b0, 1'b1, 1'b0, 8'hA5);
`ifdef FIFO_FWFT_EN
    chk("fwft_data", 32'(dout), 32'hA5);
    chk("fwft_valid", 32'(valid), 32'd1);
`else
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("a5_data", 32'(dout), 32'hA5);
    chk("a5_valid", 32'(valid), 32'd1);
`endif

    // Random traffic with shifting write/read bias and rare resets.
    for (int ph = 0; ph < 12; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
      rp = 100 - wp;
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
             WIDTH'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
